// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: group width,
// the two-level 4-bit lookahead function and the piped MSB operand bits.
package cla_pkg;

  localparam int GROUP_W = 4;

  // Operand MSBs carried down the pipe for the signed-overflow flag.
  typedef struct packed {
    logic a;
    logic b;
  } msb_bits_t;

  // Returns {carry_out, sum[3:0]}; carries are flattened to two-level
  // sum-of-products so no carry ripples inside the group.
  function automatic logic [GROUP_W:0] cla4(input logic [GROUP_W-1:0] a4,
                                            input logic [GROUP_W-1:0] b4,
                                            input logic               cin);
    logic [GROUP_W-1:0] g;
    logic [GROUP_W-1:0] p;
    logic [GROUP_W:0]   c;
    g    = a4 & b4;
    p    = a4 ^ b4;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return {c[4], p ^ c[GROUP_W-1:0]};
  endfunction

endpackage

// File: rtl/cla4_group.sv
// Purely combinational 4-bit carry-lookahead slice; one instance per pipeline stage.
module cla4_group
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a4,
  input  logic [GROUP_W-1:0] b4,
  input  logic               cin,
  output logic [GROUP_W-1:0] s4,
  output logic               cout
);

  assign {cout, s4} = cla4(a4, b4, cin);

endmodule

// File: rtl/pipelined_cla_adder.sv
// WIDTH-bit add/subtract, pipelined one 4-bit CLA group per stage, valid/ready on both sides.
// Define CLA_FLAGS_EN to build the registered ovf/zero flags; otherwise they are tied to 0.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c0,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NGROUPS = WIDTH / GROUP_W;
  localparam int LAST    = NGROUPS - 1;

  // Stage k holds result bits of groups 0..k, the carry out of group k and the
  // operands, whose slices above group k are still to be processed.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
`ifdef CLA_FLAGS_EN
    msb_bits_t        msb;
`endif
  } stage_t;

  stage_t stage_q [NGROUPS];
  stage_t stage_d [NGROUPS];

  logic [GROUP_W-1:0] grp_a  [NGROUPS];
  logic [GROUP_W-1:0] grp_b  [NGROUPS];
  logic               grp_c  [NGROUPS];
  logic [GROUP_W-1:0] grp_s  [NGROUPS];
  logic               grp_co [NGROUPS];

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // A single global enable: the whole pipe stalls only when the output slot is full.
  assign adv      = !stage_q[LAST].valid || out_ready;
  assign in_ready = adv;

  // Subtraction is A + ~B + 1; c0 is ignored in that mode.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | c0;

  always_comb begin
    grp_a[0] = a[GROUP_W-1:0];
    grp_b[0] = b_eff[GROUP_W-1:0];
    grp_c[0] = cin_eff;
    for (int k = 1; k < NGROUPS; k++) begin
      grp_a[k] = stage_q[k-1].opa[GROUP_W*k +: GROUP_W];
      grp_b[k] = stage_q[k-1].opb[GROUP_W*k +: GROUP_W];
      grp_c[k] = stage_q[k-1].carry;
    end
  end

  for (genvar k = 0; k < NGROUPS; k++) begin : g_grp
    cla4_group u_cla4 (
      .a4   (grp_a[k]),
      .b4   (grp_b[k]),
      .cin  (grp_c[k]),
      .s4   (grp_s[k]),
      .cout (grp_co[k])
    );
  end

  // NOTE: every field of every stage_d entry is assigned on every path (whole-struct
  // default first), so this block cannot infer a latch.
  always_comb begin
    stage_d[0]                    = '0;
    stage_d[0].valid              = in_valid;
    stage_d[0].res[GROUP_W-1:0]   = grp_s[0];
    stage_d[0].carry              = grp_co[0];
    stage_d[0].opa                = a;
    stage_d[0].opb                = b_eff;
`ifdef CLA_FLAGS_EN
    stage_d[0].msb.a              = a[WIDTH-1];
    stage_d[0].msb.b              = b_eff[WIDTH-1];
`endif
    for (int k = 1; k < NGROUPS; k++) begin
      stage_d[k]                            = stage_q[k-1];
      stage_d[k].res[GROUP_W*k +: GROUP_W]  = grp_s[k];
      stage_d[k].carry                      = grp_co[k];
    end
  end

  // NOTE: data registers are reset along with the valid bits so f/cout read 0
  // (not X) after reset; reset also drops every in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NGROUPS; k++) begin
        stage_q[k] <= '0;
      end
    end else if (adv) begin
      // NOTE: non-blocking so every stage samples its predecessor's pre-edge value.
      stage_q <= stage_d;
    end
  end

  assign out_valid = stage_q[LAST].valid;
  assign f         = stage_q[LAST].res;
  assign cout      = stage_q[LAST].carry;

`ifdef CLA_FLAGS_EN
  logic ovf_d;
  logic ovf_q;
  logic zero_d;
  logic zero_q;

  // Flags are formed from the final stage's next-state so they register with f.
  always_comb begin
    ovf_d  = (stage_d[LAST].msb.a == stage_d[LAST].msb.b) &&
             (stage_d[LAST].res[WIDTH-1] != stage_d[LAST].msb.a);
    zero_d = (stage_d[LAST].res == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign ovf  = ovf_q;
  assign zero = zero_q;
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

endmodule
